// File: rtl/mem2_result_reader_if.sv
// Bundle of the engine Mem2 write port and the DSP EMIF read port seen by mem2_result_reader.
// master = engine/DSP side, slave = the result reader.
interface mem2_result_reader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int OUT_WIDTH  = 32
);
  logic                  Mem2_we;
  logic [ADDR_WIDTH-1:0] Mem2_addrw;
  logic [DATA_WIDTH-1:0] Mem2_data;
  logic                  WIP_flag;
  logic                  EMIF_cs;
  logic                  EMIF_oe;
  logic [ADDR_WIDTH-1:0] EMIF_address;
  logic [OUT_WIDTH-1:0]  EMIF_data;
  logic                  EMIF_data_oe;
  logic                  bank;
  logic [15:0]           frame_count;
  logic                  overrun;
  logic                  sat;

  modport master (
    output Mem2_we, Mem2_addrw, Mem2_data, WIP_flag, EMIF_cs, EMIF_oe, EMIF_address,
    input  EMIF_data, EMIF_data_oe, bank, frame_count, overrun, sat
  );

  modport slave (
    input  Mem2_we, Mem2_addrw, Mem2_data, WIP_flag, EMIF_cs, EMIF_oe, EMIF_address,
    output EMIF_data, EMIF_data_oe, bank, frame_count, overrun, sat
  );
endinterface

// File: rtl/mem2_result_reader.sv
// Ping-pong result buffer: engine writes the hidden bank, EMIF reads the stable bank.
// Optional macro MEM2_READER_SATURATE_EN: saturate 36-bit words to 32 bits instead of truncating.
module mem2_result_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 36,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  mem2_result_reader_if.slave  bus
);
  localparam int WORDS = 2 ** (ADDR_WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, DRIVE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic                  cs_meta_q, cs_s_q, oe_meta_q, oe_s_q;
  logic [ADDR_WIDTH-1:0] addr_meta_q, addr_s_q;
  logic                  wip_q, wip_dly_q;
  logic                  pending_q, pending_d;
  logic                  bank_q, bank_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  overrun_q, overrun_d;
  logic                  sat_q, sat_d;
  logic [OUT_WIDTH-1:0]  emif_data_q, emif_data_d;
  logic                  data_oe_q, data_oe_d;
  logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  active_s, frame_end_s, swap_s, clip_s;
  logic [OUT_WIDTH-1:0]  conv_s;

`ifdef MEM2_READER_SATURATE_EN
  // Clip when the bits above the 32-bit sign position disagree with the sign.
  always_comb begin
    if ((|rd_data_q[DATA_WIDTH-1:OUT_WIDTH-1]) && !(&rd_data_q[DATA_WIDTH-1:OUT_WIDTH-1])) begin
      clip_s = 1'b1;
      conv_s = rd_data_q[DATA_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else begin
      clip_s = 1'b0;
      conv_s = rd_data_q[OUT_WIDTH-1:0];
    end
  end
`else
  logic unused_hi_s;
  assign unused_hi_s = ^rd_data_q[DATA_WIDTH-1:OUT_WIDTH];
  assign clip_s      = 1'b0;
  assign conv_s      = rd_data_q[OUT_WIDTH-1:0];
`endif

  // Next-state logic: frame-end bookkeeping, bank swap and EMIF reader FSM.
  always_comb begin
    active_s      = ~cs_s_q & ~oe_s_q;
    frame_end_s   = wip_dly_q & ~wip_q;
    swap_s        = pending_q & (state_q == IDLE);
    state_d       = state_q;
    bank_d        = bank_q;
    frame_count_d = frame_count_q;
    pending_d     = pending_q | frame_end_s;
    overrun_d     = overrun_q;
    sat_d         = sat_q;
    emif_data_d   = emif_data_q;
    data_oe_d     = data_oe_q;
    // A coincident frame end re-arms the request that this swap consumes.
    if (swap_s) begin
      bank_d        = ~bank_q;
      frame_count_d = frame_count_q + 16'd1;
      pending_d     = frame_end_s;
    end else if (frame_end_s && pending_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
    case (state_q)
      IDLE: begin
        if (active_s) state_d = ADDR;
        else          state_d = IDLE;
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        emif_data_d = conv_s;
        sat_d       = sat_q | clip_s;
        data_oe_d   = 1'b1;
        state_d     = DRIVE;
      end
      DRIVE: begin
        if (!active_s) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
        end else begin
          state_d = DRIVE;
        end
      end
      default: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // Control state, synchronizers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cs_meta_q     <= 1'b1;
      cs_s_q        <= 1'b1;
      oe_meta_q     <= 1'b1;
      oe_s_q        <= 1'b1;
      addr_meta_q   <= {ADDR_WIDTH{1'b0}};
      addr_s_q      <= {ADDR_WIDTH{1'b0}};
      wip_q         <= 1'b0;
      wip_dly_q     <= 1'b0;
      pending_q     <= 1'b0;
      bank_q        <= 1'b0;
      frame_count_q <= 16'd0;
      overrun_q     <= 1'b0;
      sat_q         <= 1'b0;
      emif_data_q   <= {OUT_WIDTH{1'b0}};
      data_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_meta_q     <= bus.EMIF_cs;
      cs_s_q        <= cs_meta_q;
      oe_meta_q     <= bus.EMIF_oe;
      oe_s_q        <= oe_meta_q;
      addr_meta_q   <= bus.EMIF_address;
      addr_s_q      <= addr_meta_q;
      wip_q         <= bus.WIP_flag;
      wip_dly_q     <= wip_q;
      pending_q     <= pending_d;
      bank_q        <= bank_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      sat_q         <= sat_d;
      emif_data_q   <= emif_data_d;
      data_oe_q     <= data_oe_d;
    end
  end

  // Both banks in one array; bank select is the top address bit, writes always hit the hidden bank.
  always_ff @(posedge clk_i) begin
    if (bus.Mem2_we) mem_q[{~bank_q, bus.Mem2_addrw}] <= bus.Mem2_data;
    if (state_q == ADDR) rd_data_q <= mem_q[{bank_q, addr_s_q}];
  end

  assign bus.EMIF_data    = emif_data_q;
  assign bus.EMIF_data_oe = data_oe_q;
  assign bus.bank         = bank_q;
  assign bus.frame_count  = frame_count_q;
  assign bus.overrun      = overrun_q;
  assign bus.sat          = sat_q;
endmodule
